gerador_jogadas: RTL and testbench
==================================

# gerador_jogadas

Hardware stimulus sequencer for the Experiment 4 control-unit circuit. It drives the circuit's `iniciar` and `chaves` inputs from a fixed step table: it pulses `iniciar`, then applies each table entry's switch value for a programmed number of clock cycles. It also monitors the circuit's `pronto` and `igual` outputs. The block sits beside `circuito_exp4` on the board and replaces manual switch operation during self-test.

## Interface
- `N_PASSOS`, default 16: number of table entries played, from 1 to 16.
- `LARG_DUR`, default 4: width of each entry's duration field.
- `clock`, input, 1 bit: system clock (50 MHz). All logic uses the rising edge.
- `reset`, input, 1 bit: asynchronous reset, active-low. `reset` = 0 forces the reset state immediately.
- `disparar`, input, 1 bit: start request, sampled on clock edges.
- `pronto_dut`, input, 1 bit: `pronto` output of the driven circuit.
- `igual_dut`, input, 1 bit: `db_igual` output of the driven circuit.
- `iniciar_dut`, output, 1 bit: drives the circuit's `iniciar` input.
- `chaves_dut`, output, 4 bits: drives the circuit's `chaves` input.
- `executando`, output, 1 bit: high while a sequence is being played.
- `terminado`, output, 1 bit: high once the sequence has completed; stays high until the next start.
- `passo`, output, 4 bits: index of the current table entry.
- `acertos`, output, 5 bits: number of steps in which `igual_dut` was seen high.
- `erro`, output, 1 bit: high when `pronto_dut` arrived before the last step.
- `db_estado`, output, 4 bits: FSM state code, for the 7-segment display.

## Operation
- Moore FSM with these state codes:
  - OCIOSO = 0
  - INICIA = 1
  - APLICA = 2
  - FIM = 3
  - ERRO = E
- All outputs are registered.
- Reset values of all outputs: 0. This includes `chaves_dut` = 0000 and `db_estado` = 0.
- OCIOSO:
  - `disparar` = 1 moves to INICIA.
  - The transition clears `passo`, `acertos` and `erro`.
- INICIA lasts exactly 1 cycle:
  - `iniciar_dut` = 1.
  - `chaves_dut` = chaves[0].
  - `executando` = 1.
  - Next state is APLICA with `passo` = 0.
- APLICA:
  - `chaves_dut` = chaves[`passo`]. It is held for dur[`passo`] cycles, using an internal down-counter of `LARG_DUR` bits.
  - A duration of 0 is treated as 1.
  - When the counter expires and `passo` < `N_PASSOS`-1: `passo` increments, the next value is applied the following cycle, with no gap cycle.
  - When the counter expires and `passo` = `N_PASSOS`-1: move to FIM.
- FIM:
  - `terminado` = 1, `executando` = 0.
  - `chaves_dut` returns to 0000.
  - `disparar` = 1 restarts at INICIA and clears all counters.
- ERRO (only with checking compiled in):
  - `erro` = 1, `executando` = 0, `chaves_dut` = 0000.
  - Left only through `disparar` (goes to INICIA) or reset.
- `disparar` is ignored in INICIA and APLICA.
- `acertos`:
  - Increments at most once per step, on the first cycle of that step in which `igual_dut` = 1. A per-step flag enforces this.
  - Saturates at 31.
- Early `pronto_dut`: `pronto_dut` = 1 in APLICA while `passo` < `N_PASSOS`-1 moves to ERRO on the next edge.
- `pronto_dut` during the last step, or during FIM, is legal.
- Default step table, indices 0–15:
  - chaves = 4,4,4,4,4,4,1,2,4,8,1,2,0,0,0,0
  - dur = 1,1,1,3,3,9,6,6,6,6,3,6,1,1,1,1
  - Sum of durations for the full table: 55.

## Timing
- `disparar` sampled high at edge k gives:
  - INICIA during cycle k+1.
  - First APLICA cycle at k+2.
- With the default table, `terminado` rises 56 cycles after `iniciar_dut` rises.
- Reset asserted mid-sequence: outputs go to their reset values asynchronously, with no completion pulse. The FSM restarts in OCIOSO on the first edge after release.
- `disparar` arriving in the same cycle as FIM entry is not seen until FIM is registered. FIM is therefore always visible for at least 1 cycle.
- The inputs are assumed synchronous to `clock`; this block does not synchronize them.

## Configuration
- `GERADOR_CHECK_EN` defined:
  - `acertos` counter and the early-`pronto` check are built.
  - ERRO state is reachable.
- Undefined:
  - `acertos` is tied to 0 and `erro` is tied to 0.
  - `pronto_dut` and `igual_dut` are ignored, and ERRO is not synthesized.
  - Sequencing and timing are identical to the checked build.

## Structure
- Package `gerador_jogadas_pkg` holds:
  - the state encoding constants;
  - the step-entry typedef (4-bit chaves, `LARG_DUR`-bit duration);
  - the default table constant.
- Sub-module `rom_passos`: combinational lookup from `passo` to {chaves, dur}, reading from the package table.

## Test plan
- Reset held low, then released, 5 cycles idle: all outputs 0, `db_estado` = 0.
- `disparar` for 1 cycle, `pronto_dut` = 0 and `igual_dut` = 0:
  - `iniciar_dut` high for exactly 1 cycle with `chaves_dut` = 0100.
  - Then `chaves_dut` follows the table, e.g. 0100 held 9 cycles at `passo` 5, 1000 held 6 cycles at `passo` 9.
  - `terminado` = 1 exactly 56 cycles after `iniciar_dut`.
  - `acertos` = 0.
- `igual_dut` high during steps 0–3, including 3 cycles within step 3: `acertos` = 4 at FIM.
- `pronto_dut` pulsed at `passo` = 7: ERRO entered next cycle, `erro` = 1, `chaves_dut` = 0000. A subsequent `disparar` restarts the sequence with `erro` = 0.
- Reset driven low at `passo` = 9, then released: outputs immediately 0, FSM back in OCIOSO. `disparar` pulses during APLICA have no effect.
- Build without `GERADOR_CHECK_EN`, with `pronto_dut` = 1 throughout: full 56-cycle sequence completes, `erro` = 0, `acertos` = 0.

Source files
------------

// File: rtl/gerador_jogadas_pkg.sv
// Shared definitions for the gerador_jogadas stimulus sequencer:
// FSM state codes, the step-entry type and the default step table.
package gerador_jogadas_pkg;

    // State codes are also shown on the 7-segment display via db_estado
    typedef enum logic [3:0] {
        OCIOSO = 4'h0,
        INICIA = 4'h1,
        APLICA = 4'h2,
        FIM    = 4'h3,
        ERRO   = 4'hE
    } estado_t;

    // Geometry of the stored table; the sequencer may use fewer entries
    // or a different duration width, the lookup adapts it.
    localparam int N_TAB        = 16;
    localparam int LARG_DUR_TAB = 4;

    // One table entry: switch value and number of cycles it is held
    typedef struct packed {
        logic [3:0]              chaves;
        logic [LARG_DUR_TAB-1:0] dur;
    } entrada_t;

    // Default self-test sequence; durations add up to 55 cycles
    localparam entrada_t TABELA_PADRAO [N_TAB] = '{
        '{4'd4, 4'd1}, '{4'd4, 4'd1}, '{4'd4, 4'd1}, '{4'd4, 4'd3},
        '{4'd4, 4'd3}, '{4'd4, 4'd9}, '{4'd1, 4'd6}, '{4'd2, 4'd6},
        '{4'd4, 4'd6}, '{4'd8, 4'd6}, '{4'd1, 4'd3}, '{4'd2, 4'd6},
        '{4'd0, 4'd1}, '{4'd0, 4'd1}, '{4'd0, 4'd1}, '{4'd0, 4'd1}
    };

endpackage

// File: rtl/gerador_jogadas_rom_passos.sv
// rom_passos: combinational lookup of the step table, index -> {chaves, dur}.
// The duration field is resized to the width the sequencer counts with.
module rom_passos
    import gerador_jogadas_pkg::*;
#(
    parameter int LARG_DUR = 4
) (
    input  logic [3:0]          passo,
    output logic [3:0]          chaves,
    output logic [LARG_DUR-1:0] dur
);

    logic [3:0]          chaves_tab [N_TAB];
    logic [LARG_DUR-1:0] dur_tab    [N_TAB];

    generate
        for (genvar gi = 0; gi < N_TAB; gi++) begin : g_tab
            assign chaves_tab[gi] = TABELA_PADRAO[gi].chaves;
            assign dur_tab[gi]    = LARG_DUR'(TABELA_PADRAO[gi].dur);
        end
    endgenerate

    assign chaves = chaves_tab[passo];
    assign dur    = dur_tab[passo];

endmodule

// File: rtl/gerador_jogadas.sv
// gerador_jogadas: plays the step table into circuito_exp4 (iniciar pulse,
// then each chaves value for its duration) and watches pronto/db_igual.
// Build option: GERADOR_CHECK_EN enables the acertos counter, the early
// pronto check and the ERRO state; without it acertos and erro read 0.
module gerador_jogadas
    import gerador_jogadas_pkg::*;
#(
    parameter int N_PASSOS = 16,
    parameter int LARG_DUR = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       disparar,
    input  logic       pronto_dut,
    input  logic       igual_dut,
    output logic       iniciar_dut,
    output logic [3:0] chaves_dut,
    output logic       executando,
    output logic       terminado,
    output logic [3:0] passo,
    output logic [4:0] acertos,
    output logic       erro,
    output logic [3:0] db_estado
);

    localparam logic [3:0] ULTIMO = 4'(N_PASSOS - 1);

    estado_t             estado_reg, estado_next;
    logic [3:0]          passo_reg, passo_next;
    logic [LARG_DUR-1:0] cnt_reg, cnt_next;
    logic [4:0]          acertos_reg, acertos_next;
    logic                erro_next;
    logic                iniciar_next, executando_next, terminado_next;
    logic [3:0]          chaves_next;

    logic [3:0]          rom_chaves;
    logic [LARG_DUR-1:0] rom_dur;
    logic [LARG_DUR-1:0] dur_eff;
    logic                expira, ultimo, avanca;

    // The table is addressed with the step that will be current next cycle,
    // so the registered chaves_dut and the reloaded counter line up with it.
    rom_passos #(.LARG_DUR(LARG_DUR)) u_rom (
        .passo  (passo_next),
        .chaves (rom_chaves),
        .dur    (rom_dur)
    );

    // A zero duration still occupies one cycle
    assign dur_eff = (rom_dur == '0) ? LARG_DUR'(1) : rom_dur;
    assign expira  = (cnt_reg == LARG_DUR'(1));
    assign ultimo  = (passo_reg == ULTIMO);
    assign avanca  = (estado_reg == APLICA) && (estado_next == APLICA) && expira;

`ifdef GERADOR_CHECK_EN
    logic pronto_cedo;
    logic hit_reg, hit_next;
    assign pronto_cedo = pronto_dut && !ultimo;
`else
    logic unused_entradas;
    assign unused_entradas = pronto_dut ^ igual_dut;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_reg <= OCIOSO;
        end else begin
            estado_reg <= estado_next;
        end
    end

    // Next-state logic; disparar only matters outside INICIA/APLICA
    always_comb begin
        estado_next = estado_reg;
        case (estado_reg)
            OCIOSO: if (disparar) estado_next = INICIA;
            INICIA: estado_next = APLICA;
            APLICA: begin
`ifdef GERADOR_CHECK_EN
                if (pronto_cedo)
                    estado_next = ERRO;
                else
`endif
                if (expira && ultimo)
                    estado_next = FIM;
            end
            FIM, ERRO: if (disparar) estado_next = INICIA;
            default: estado_next = OCIOSO;
        endcase
    end

    // Step index: cleared on every start, advances when a step expires
    always_comb begin
        passo_next = passo_reg;
        if (estado_next == INICIA)
            passo_next = '0;
        else if (avanca)
            passo_next = passo_reg + 4'd1;
    end

    // Duration down-counter: reloaded at the start of each step
    always_comb begin
        cnt_next = cnt_reg;
        if ((estado_reg == INICIA) || avanca)
            cnt_next = dur_eff;
        else if (estado_reg == APLICA)
            cnt_next = cnt_reg - LARG_DUR'(1);
    end

`ifdef GERADOR_CHECK_EN
    // Hit counter: one count per step at most, saturating at 31
    always_comb begin
        acertos_next = acertos_reg;
        hit_next     = hit_reg;
        if (estado_next == INICIA) begin
            acertos_next = '0;
            hit_next     = 1'b0;
        end else if (estado_reg == APLICA) begin
            if (igual_dut && !hit_reg) begin
                if (acertos_reg != 5'd31)
                    acertos_next = acertos_reg + 5'd1;
                hit_next = 1'b1;
            end
            if (expira)
                hit_next = 1'b0;
        end
    end

    // Per-step hit flag register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_reg <= 1'b0;
        end else begin
            hit_reg <= hit_next;
        end
    end
`else
    assign acertos_next = '0;
`endif

    // Moore outputs, computed from the upcoming state and then registered
    always_comb begin
        iniciar_next    = (estado_next == INICIA);
        executando_next = (estado_next == INICIA) || (estado_next == APLICA);
        terminado_next  = (estado_next == FIM);
        erro_next       = (estado_next == ERRO);
        chaves_next     = executando_next ? rom_chaves : 4'b0000;
    end

    // Output and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            iniciar_dut <= 1'b0;
            chaves_dut  <= 4'b0000;
            executando  <= 1'b0;
            terminado   <= 1'b0;
            erro        <= 1'b0;
            passo_reg   <= '0;
            cnt_reg     <= '0;
            acertos_reg <= '0;
        end else begin
            iniciar_dut <= iniciar_next;
            chaves_dut  <= chaves_next;
            executando  <= executando_next;
            terminado   <= terminado_next;
            erro        <= erro_next;
            passo_reg   <= passo_next;
            cnt_reg     <= cnt_next;
            acertos_reg <= acertos_next;
        end
    end

    assign passo     = passo_reg;
    assign acertos   = acertos_reg;
    assign db_estado = estado_reg;

endmodule

// File: tb/tb_gerador_jogadas.sv
// Testbench for gerador_jogadas: stimulus pushes time-tagged expectations
// into a queue; a monitor on the falling edge pops and compares them.
module tb_gerador_jogadas;

    logic       clock = 1'b0;
    logic       reset;
    logic       disparar;
    logic       pronto_dut;
    logic       igual_dut;
    logic       iniciar_dut;
    logic [3:0] chaves_dut;
    logic       executando;
    logic       terminado;
    logic [3:0] passo;
    logic [4:0] acertos;
    logic       erro;
    logic [3:0] db_estado;

    gerador_jogadas #(.N_PASSOS(16), .LARG_DUR(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .disparar    (disparar),
        .pronto_dut  (pronto_dut),
        .igual_dut   (igual_dut),
        .iniciar_dut (iniciar_dut),
        .chaves_dut  (chaves_dut),
        .executando  (executando),
        .terminado   (terminado),
        .passo       (passo),
        .acertos     (acertos),
        .erro        (erro),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    localparam int S_INI = 0, S_CHV = 1, S_EXE = 2, S_TER = 3;
    localparam int S_PAS = 4, S_ACE = 5, S_ERR = 6, S_EST = 7;

    // Hand-written copy of the default table
    int tab_ch  [16] = '{4,4,4,4,4,4,1,2,4,8,1,2,0,0,0,0};
    int tab_dur [16] = '{1,1,1,3,3,9,6,6,6,6,3,6,1,1,1,1};

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [7:0] sinal(int s);
        case (s)
            S_INI:   return {7'd0, iniciar_dut};
            S_CHV:   return {4'd0, chaves_dut};
            S_EXE:   return {7'd0, executando};
            S_TER:   return {7'd0, terminado};
            S_PAS:   return {4'd0, passo};
            S_ACE:   return {3'd0, acertos};
            S_ERR:   return {7'd0, erro};
            default: return {4'd0, db_estado};
        endcase
    endfunction

    function automatic string nome(int s);
        case (s)
            S_INI:   return "iniciar_dut";
            S_CHV:   return "chaves_dut";
            S_EXE:   return "executando";
            S_TER:   return "terminado";
            S_PAS:   return "passo";
            S_ACE:   return "acertos";
            S_ERR:   return "erro";
            default: return "db_estado";
        endcase
    endfunction

    // Sorted insert so expectations may be pushed in any order
    task automatic expect_at(int c, int s, int v);
        exp_t e;
        int   i;
        e.cyc = c;
        e.sig = s;
        e.val = 8'(v);
        i = exp_q.size();
        while (i > 0 && exp_q[i-1].cyc > c) i--;
        exp_q.insert(i, e);
    endtask

    task automatic expect_zero(int c);
        for (int k = 0; k < 8; k++) expect_at(c, k, 0);
    endtask

    // Immediate comparison of one signal against its required value
    task automatic check_now(int s, int v);
        logic [7:0] act;
        act = sinal(s);
        checks++;
        if (act !== 8'(v)) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h (immediate)",
                     nome(s), cyc, act, 8'(v));
        end else begin
            $display("ok   %s cyc=%0d value=%0h (immediate)", nome(s), cyc, act);
        end
    endtask

    // Expected trace of a sequence whose INICIA cycle is s, up to cycle 'ate'
    task automatic push_seq(int s, int ate, int ac_fim);
        int c;
        expect_at(s, S_INI, 1);
        expect_at(s, S_CHV, tab_ch[0]);
        expect_at(s, S_EXE, 1);
        expect_at(s, S_TER, 0);
        expect_at(s, S_PAS, 0);
        expect_at(s, S_ACE, 0);
        expect_at(s, S_ERR, 0);
        expect_at(s, S_EST, 1);
        c = s + 1;
        for (int p = 0; p < 16; p++) begin
            for (int k = 0; k < tab_dur[p]; k++) begin
                if (c <= ate) begin
                    expect_at(c, S_INI, 0);
                    expect_at(c, S_CHV, tab_ch[p]);
                    expect_at(c, S_PAS, p);
                    expect_at(c, S_EXE, 1);
                    expect_at(c, S_TER, 0);
                    expect_at(c, S_EST, 2);
                end
                c++;
            end
        end
        for (int f = s + 56; f <= ate; f++) begin
            expect_at(f, S_TER, 1);
            expect_at(f, S_EXE, 0);
            expect_at(f, S_CHV, 0);
            expect_at(f, S_EST, 3);
            expect_at(f, S_PAS, 15);
            expect_at(f, S_ACE, ac_fim);
            expect_at(f, S_ERR, 0);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_seq(output int s);
        disparar = 1'b1;
        s = cyc + 1;
        $display("seq start: iniciar expected at cyc=%0d", s);
        tick();
        disparar = 1'b0;
    endtask

    // Monitor: compare every expectation due at this cycle
    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t       e;
            logic [7:0] act;
            e   = exp_q.pop_front();
            act = sinal(e.sig);
            checks++;
            if (e.cyc != cyc || act !== e.val) begin
                failures++;
                $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                         nome(e.sig), e.cyc, act, e.val);
            end
        end
    end

    initial begin
        int s, s2, s3;
        reset      = 1'b0;
        disparar   = 1'b0;
        pronto_dut = 1'b0;
        igual_dut  = 1'b0;

        // Reset held, then idle
        tick(); tick();
        expect_zero(cyc);
        tick();
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) expect_zero(cyc + i);
        repeat (5) tick();

        // Plain run; disparar pulses during APLICA must be ignored
        start_seq(s);
        push_seq(s, s + 57, 0);
        while (cyc < s + 58) begin
            disparar = (cyc == s + 10) || (cyc == s + 40);
            tick();
        end
        disparar = 1'b0;

        // igual during steps 0..3; pronto legal in last step and in FIM
        start_seq(s);
`ifdef GERADOR_CHECK_EN
        push_seq(s, s + 57, 4);
        expect_at(s + 2, S_ACE, 1);
        expect_at(s + 5, S_ACE, 4);
        expect_at(s + 7, S_ACE, 4);
        while (cyc < s + 58) begin
            igual_dut  = (cyc >= s + 1) && (cyc <= s + 6);
            pronto_dut = (cyc >= s + 55);
            tick();
        end
`else
        push_seq(s, s + 57, 0);
        expect_at(s + 30, S_ERR, 0);
        expect_at(s + 7, S_ACE, 0);
        while (cyc < s + 58) begin
            igual_dut  = (cyc >= s + 1) && (cyc <= s + 6);
            pronto_dut = 1'b1;
            tick();
        end
`endif
        igual_dut  = 1'b0;
        pronto_dut = 1'b0;

        // Early pronto at passo 7
        start_seq(s);
`ifdef GERADOR_CHECK_EN
        push_seq(s, s + 25, 0);
        for (int c = s + 26; c <= s + 28; c++) begin
            expect_at(c, S_EST, 14);
            expect_at(c, S_ERR, 1);
            expect_at(c, S_CHV, 0);
            expect_at(c, S_EXE, 0);
            expect_at(c, S_INI, 0);
            expect_at(c, S_TER, 0);
        end
        while (cyc < s + 28) begin
            pronto_dut = (cyc == s + 25);
            tick();
        end
`else
        push_seq(s, s + 57, 0);
        expect_at(s + 26, S_ERR, 0);
        while (cyc < s + 58) begin
            pronto_dut = (cyc == s + 25);
            tick();
        end
`endif
        pronto_dut = 1'b0;

        // Restart, then reset during passo 9
        start_seq(s2);
        push_seq(s2, s2 + 37, 0);
        while (cyc < s2 + 38) tick();
        reset = 1'b0;
        $display("reset asserted at cyc=%0d", cyc);
        #1;
        check_now(S_EST, 0);
        check_now(S_CHV, 0);
        check_now(S_EXE, 0);
        check_now(S_INI, 0);
        check_now(S_PAS, 0);
        check_now(S_TER, 0);
        check_now(S_ERR, 0);
        expect_zero(cyc);
        tick();
        expect_zero(cyc);
        tick();
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) expect_zero(cyc + i);
        repeat (3) tick();

        // Sequencer accepts a new start after reset
        start_seq(s3);
        push_seq(s3, s3 + 3, 0);

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL wait expired cyc=%0d pending=%0d required=0",
                     cyc, exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
